// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one single-port 1024x32 SRAM
// between port 0 (CPU side) and port 1 (DMA side). One SRAM access per
// cycle; read data returns one cycle after the grant.
// Optional byte-write support: define SRAM_ARB_BWE_EN to add the wstrb
// ports and the read-modify-write MERGE cycle for partial strobes.
module sram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
`ifdef SRAM_ARB_BWE_EN
    input  logic [3:0]        m0_wstrb,
`endif
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
`ifdef SRAM_ARB_BWE_EN
    input  logic [3:0]        m1_wstrb,
`endif
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              sram_cs,
    output logic              sram_web,
    output logic              sram_oe,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_di,
    input  logic [DATA_W-1:0] sram_do
);

    logic              r_rr_last;
    logic              r_rvalid;
    logic              r_tag;

    logic              w_idle;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any;
    logic              w_sel;
    logic              w_we;
    logic              w_read;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

`ifdef SRAM_ARB_BWE_EN
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_MERGE = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic [3:0]        r_m_wstrb;

    logic [3:0]        w_wstrb;
    logic              w_nostrb;
    logic              w_rmw;
    logic [DATA_W-1:0] w_merge;

    assign w_idle = (r_state == S_IDLE);
`else
    assign w_idle = 1'b1;
`endif

    // Round-robin pick: a lone request wins, a tie goes to the port that did not win last.
    always_comb begin
        w_gnt1  = ~rst & w_idle & m1_req & (~m0_req | ~r_rr_last);
        w_gnt0  = ~rst & w_idle & m0_req & ~w_gnt1;
        w_any   = w_gnt0 | w_gnt1;
        w_sel   = w_gnt1;
        w_we    = w_sel ? m1_we    : m0_we;
        w_addr  = w_sel ? m1_addr  : m0_addr;
        w_wdata = w_sel ? m1_wdata : m0_wdata;
        w_read  = w_any & ~w_we;
`ifdef SRAM_ARB_BWE_EN
        w_wstrb  = w_sel ? m1_wstrb : m0_wstrb;
        w_nostrb = (w_wstrb == 4'h0);
        w_rmw    = w_any & w_we & ~w_nostrb & (w_wstrb != 4'hF);
`endif
    end

`ifdef SRAM_ARB_BWE_EN
    // Byte merge of captured write data over the word read back in the first RMW cycle.
    always_comb begin
        w_merge = sram_do;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_m_wstrb[i]) begin
                w_merge[8*i +: 8] = r_m_wdata[8*i +: 8];
            end
        end
    end
`endif

    // SRAM command: granted access this cycle, or the write phase of a pending RMW.
    always_comb begin
        sram_cs  = 1'b0;
        sram_web = 1'b1;
        sram_a   = w_addr;
        sram_di  = w_wdata;
        sram_oe  = ~rst;
        if (w_any) begin
            sram_cs  = 1'b1;
            sram_web = ~w_we;
        end
`ifdef SRAM_ARB_BWE_EN
        // A partial-strobe write first reads the word; an empty strobe touches nothing.
        if (w_any && w_we && w_nostrb) begin
            sram_cs = 1'b0;
        end
        if (w_rmw) begin
            sram_web = 1'b1;
        end
        if (!rst && r_state == S_MERGE) begin
            sram_cs  = 1'b1;
            sram_web = 1'b0;
            sram_a   = r_m_addr;
            sram_di  = w_merge;
        end
`endif
    end

    // Arbitration history, read-return valid and the port tag for the returning data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last <= 1'b1;
            r_rvalid  <= 1'b0;
            r_tag     <= 1'b0;
        end else begin
            r_rvalid <= w_read;
            if (w_read) begin
                r_tag <= w_sel;
            end
            if (w_any) begin
                r_rr_last <= w_sel;
            end
        end
    end

`ifdef SRAM_ARB_BWE_EN
    // RMW sequencing: capture the partial write in IDLE, write the merged word in MERGE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_wstrb <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rmw) begin
                        r_state   <= S_MERGE;
                        r_m_addr  <= w_addr;
                        r_m_wdata <= w_wdata;
                        r_m_wstrb <= w_wstrb;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`endif

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_rvalid = r_rvalid & ~r_tag;
    assign m1_rvalid = r_rvalid &  r_tag;
    assign m0_rdata  = sram_do;
    assign m1_rdata  = sram_do;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: behavioural SRAM, reference memory model and
// a read-return scoreboard. Define SRAM_ARB_BWE_EN to also exercise the
// byte-strobe / read-modify-write path.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [9:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        sram_cs, sram_web, sram_oe;
    logic [9:0]  sram_a;
    logic [31:0] sram_di, sram_do;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
`ifdef SRAM_ARB_BWE_EN
        .m0_wstrb(m0_wstrb),
`endif
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
`ifdef SRAM_ARB_BWE_EN
        .m1_wstrb(m1_wstrb),
`endif
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .sram_cs(sram_cs), .sram_web(sram_web), .sram_oe(sram_oe),
        .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
    );

    // Behavioural SRAM: write on edge, registered read; loader port for preload.
    logic [31:0] sram_mem [1024];
    logic        ld_en = 1'b0;
    logic [9:0]  ld_a  = '0;
    logic [31:0] ld_d  = '0;
    always @(posedge clk) begin
        if (ld_en) sram_mem[ld_a] <= ld_d;
        else if (sram_cs) begin
            if (!sram_web) sram_mem[sram_a] <= sram_di;
            else           sram_do <= sram_mem[sram_a];
        end
    end

    // Reference model state
    typedef struct { bit port; logic [31:0] data; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] ref_mem [1024];
    bit          m_rr;
    bit          m_busy;
    logic [9:0]  m_maddr;
    logic        p_req [2];
    logic        p_we [2];
    logic [9:0]  p_addr [2];
    logic [31:0] p_wdata [2];
    logic [3:0]  p_wstrb [2];

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    task automatic drive();
        m0_req = p_req[0]; m0_we = p_we[0]; m0_addr = p_addr[0];
        m0_wdata = p_wdata[0]; m0_wstrb = p_wstrb[0];
        m1_req = p_req[1]; m1_we = p_we[1]; m1_addr = p_addr[1];
        m1_wdata = p_wdata[1]; m1_wstrb = p_wstrb[1];
    endtask

    task automatic set_req(int k, logic we, logic [9:0] a, logic [31:0] d, logic [3:0] s);
        p_req[k] = 1'b1; p_we[k] = we; p_addr[k] = a; p_wdata[k] = d; p_wstrb[k] = s;
    endtask

    function automatic logic [9:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 10'h3FF;
            1:       return 10'h010;
            2:       return 10'($urandom_range(0, 1023));
            default: return 10'($urandom_range(0, 15));
        endcase
    endfunction

    // One clock cycle: present pending requests, predict grant and SRAM select,
    // and apply the accepted request to the reference memory.
    task automatic step();
        logic        eg0, eg1, ecs, pp;
        logic [3:0]  st;
        logic [31:0] nv;
        logic [9:0]  a;
        int          k;
        @(negedge clk);
        drive();
        #1;
        eg0 = 1'b0; eg1 = 1'b0;
        if (!m_busy) begin
            if (p_req[0] && p_req[1]) begin
                if (m_rr) eg0 = 1'b1; else eg1 = 1'b1;
            end else begin
                eg0 = p_req[0]; eg1 = p_req[1];
            end
        end
        chk("m0_gnt", 32'(m0_gnt), 32'(eg0));
        chk("m1_gnt", 32'(m1_gnt), 32'(eg1));
        ecs = m_busy;
        if (m_busy) begin
            chk("merge_web", 32'(sram_web), 32'(0));
            chk("merge_addr", 32'(sram_a), 32'(m_maddr));
        end
        m_busy = 1'b0;
        if (eg0 || eg1) begin
            pp = eg1;
            k = eg1 ? 1 : 0;
            m_rr = pp;
            a = p_addr[k];
`ifdef SRAM_ARB_BWE_EN
            st = p_wstrb[k];
`else
            st = 4'hF;
`endif
            if (!p_we[k]) begin
                ecs = 1'b1;
                exp_q.push_back('{pp, ref_mem[a]});
            end else if (st != 4'h0) begin
                ecs = 1'b1;
                nv = ref_mem[a];
                for (int b = 0; b < 4; b++)
                    if (st[b]) nv[8*b +: 8] = p_wdata[k][8*b +: 8];
                ref_mem[a] = nv;
                if (st != 4'hF) begin
                    m_busy = 1'b1;
                    m_maddr = a;
                end
            end
            p_req[k] = 1'b0;
        end
        chk("sram_cs", 32'(sram_cs), 32'(ecs));
        @(posedge clk);
    endtask

    // Monitor: every read grant must return on the following cycle, on the right port.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.port == 1'b0) begin
                    chk("m0_rvalid", 32'(m0_rvalid), 32'(1));
                    chk("m1_rvalid_quiet", 32'(m1_rvalid), 32'(0));
                    if (m0_rvalid) chk("m0_rdata", m0_rdata, e.data);
                end else begin
                    chk("m1_rvalid", 32'(m1_rvalid), 32'(1));
                    chk("m0_rvalid_quiet", 32'(m0_rvalid), 32'(0));
                    if (m1_rvalid) chk("m1_rdata", m1_rdata, e.data);
                end
            end else begin
                chk("rvalid_none", 32'({m0_rvalid, m1_rvalid}), 32'(0));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int          bad;
        for (int k = 0; k < 2; k++) begin
            p_req[k] = 1'b0; p_we[k] = 1'b0; p_addr[k] = '0; p_wdata[k] = '0; p_wstrb[k] = 4'hF;
        end
        m_rr = 1'b1; m_busy = 1'b0; m_maddr = '0;
        // Reset state with a request pending: nothing may be granted or selected.
        set_req(0, 1'b0, 10'h005, 32'h0, 4'hF);
        drive();
        #3;
        chk("rst_m0_gnt", 32'(m0_gnt), 32'(0));
        chk("rst_cs", 32'(sram_cs), 32'(0));
        chk("rst_oe", 32'(sram_oe), 32'(0));
        chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'(0));
        p_req[0] = 1'b0;
        drive();

        for (int i = 0; i < 1024; i++) begin
            v = (i == 5) ? 32'hDEADBEEF : (i == 32) ? 32'h12345678 : $urandom;
            ref_mem[i] = v;
            @(negedge clk);
            ld_en = 1'b1; ld_a = 10'(i); ld_d = v;
        end
        @(negedge clk);
        ld_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("run_oe", 32'(sram_oe), 32'(1));

        // Single read of preloaded word
        set_req(0, 1'b0, 10'h005, 32'h0, 4'hF);
        step();
        step();

        // Both ports requesting continuously: write then read of 0x3FF
        for (int c = 0; c < 4; c++) begin
            if (!p_req[0]) set_req(0, 1'b1, 10'h3FF, 32'h11111111, 4'hF);
            if (!p_req[1]) set_req(1, 1'b0, 10'h3FF, 32'h0, 4'hF);
            step();
        end
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        step();

        // Write on m1 followed by read of the same word on m0 next cycle
        set_req(1, 1'b1, 10'h010, 32'hA5A5A5A5, 4'hF);
        step();
        set_req(0, 1'b0, 10'h010, 32'h0, 4'hF);
        step();
        step();

        // Reset the cycle after a read grant: the return is dropped
        set_req(0, 1'b0, 10'h007, 32'h0, 4'hF);
        step();
        rst = 1'b1;
        exp_q.delete();
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        drive();
        #1;
        chk("midrst_cs", 32'(sram_cs), 32'(0));
        chk("midrst_oe", 32'(sram_oe), 32'(0));
        chk("midrst_m0_rvalid", 32'(m0_rvalid), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        m_rr = 1'b1; m_busy = 1'b0;
        set_req(0, 1'b0, 10'h001, 32'h0, 4'hF);
        set_req(1, 1'b0, 10'h002, 32'h0, 4'hF);
        step();
        step();
        step();

`ifdef SRAM_ARB_BWE_EN
        // Partial-strobe write: read, then merged write while m1 waits
        set_req(0, 1'b1, 10'h020, 32'hAABBCCDD, 4'b0101);
        step();
        set_req(1, 1'b0, 10'h021, 32'h0, 4'hF);
        step();
        step();
        set_req(0, 1'b0, 10'h020, 32'h0, 4'hF);
        step();
        // Empty strobe: granted with no SRAM access
        set_req(1, 1'b1, 10'h021, 32'hFFFFFFFF, 4'h0);
        step();
        set_req(0, 1'b0, 10'h021, 32'h0, 4'hF);
        step();
        step();
`endif

        // Randomized traffic
        for (int c = 0; c < 500; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!p_req[k] && $urandom_range(0, 2) != 0) begin
                    case ($urandom_range(0, 3))
                        0:       v[3:0] = 4'h0;
                        1:       v[3:0] = 4'($urandom_range(1, 14));
                        default: v[3:0] = 4'hF;
                    endcase
                    set_req(k, 1'($urandom_range(0, 1)), rand_addr(), $urandom, v[3:0]);
                end
            end
            step();
        end
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        step();
        step();

        bad = 0;
        for (int i = 0; i < 1024; i++)
            if (sram_mem[i] !== ref_mem[i]) bad++;
        chk("mem_contents_bad_words", 32'(bad), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
